// File: rtl/fu_br_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fu_br_pipe_pkg
// Description : Branch opcode encodings and decode helpers for fu_br_pipe.
// Revision    : 1.0  initial release
// ============================================================================
package fu_br_pipe_pkg;

    localparam int BR_OP_BEQ  = 0;
    localparam int BR_OP_BNE  = 1;
    localparam int BR_OP_BLT  = 4;
    localparam int BR_OP_BGE  = 5;
    localparam int BR_OP_BLTU = 6;
    localparam int BR_OP_BGEU = 7;
    localparam int BR_OP_JAL  = 8;
    localparam int BR_OP_JALR = 9;

    localparam int BR_PC_WIDTH_DEF   = 32;
    localparam int BR_WORD_WIDTH_DEF = 32;

    function automatic logic br_is_link(input int op);
        return (op == BR_OP_JAL) || (op == BR_OP_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_br_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fu_br_pipe_if
// Description : Issue, flush and result handshake bundle of the branch unit.
// Revision    : 1.0  initial release
// ============================================================================
interface fu_br_pipe_if #(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 32,
    parameter int ROB_DEPTH  = 32,
    parameter int OP_WIDTH   = 4,
    parameter int CNT_WIDTH  = 32
) ();
    localparam int c_ROB_W = $clog2(ROB_DEPTH);

    logic                  flush;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [OP_WIDTH-1:0]   issue_op;
    logic [PC_WIDTH-1:0]   issue_pc;
    logic [WORD_WIDTH-1:0] issue_imm;
    logic [WORD_WIDTH-1:0] issue_rs1;
    logic [WORD_WIDTH-1:0] issue_rs2;
    logic [c_ROB_W-1:0]    issue_rob;
    logic                  issue_pred_taken;
    logic [PC_WIDTH-1:0]   issue_pred_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_ROB_W-1:0]    out_rob;
    logic                  out_taken;
    logic [PC_WIDTH-1:0]   out_next_pc;
    logic                  out_mispredict;
    logic                  out_misalign;
    logic [WORD_WIDTH-1:0] out_link;
    logic                  out_link_valid;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;

    modport master (
        output flush, issue_valid, issue_op, issue_pc, issue_imm, issue_rs1,
               issue_rs2, issue_rob, issue_pred_taken, issue_pred_addr, out_ready,
        input  issue_ready, out_valid, out_rob, out_taken, out_next_pc,
               out_mispredict, out_misalign, out_link, out_link_valid, mispredict_cnt
    );

    modport slave (
        input  flush, issue_valid, issue_op, issue_pc, issue_imm, issue_rs1,
               issue_rs2, issue_rob, issue_pred_taken, issue_pred_addr, out_ready,
        output issue_ready, out_valid, out_rob, out_taken, out_next_pc,
               out_mispredict, out_misalign, out_link, out_link_valid, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fu_br_pipe_br_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_result_fifo
// Description : Synchronous result FIFO with flush; head reads as zero when empty.
// Revision    : 1.0  initial release
// ============================================================================
module br_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign w_pop   = pop & ~w_empty;
    assign w_push  = push & (~w_full | w_pop);

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (c_PTR_W+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (c_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_valid = ~w_empty;
    assign head_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/fu_br_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fu_br_pipe
// Description : Pipelined branch/jump resolve unit with result FIFO and
//               mispredict counter.
// Revision    : 1.0  initial release
// ============================================================================
module fu_br_pipe
    import fu_br_pipe_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 32,
    parameter int ROB_DEPTH  = 32,
    parameter int OP_WIDTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic       clk,
    input  logic       rst,
    fu_br_pipe_if.slave bus
);
    localparam int c_ROB_W = $clog2(ROB_DEPTH);
    localparam int c_CNT_W = $clog2(OUT_DEPTH) + 1;

    typedef struct packed {
        logic [c_ROB_W-1:0]    rob;
        logic                  taken;
        logic [PC_WIDTH-1:0]   next_pc;
        logic                  mispredict;
        logic                  misalign;
        logic [WORD_WIDTH-1:0] link;
        logic                  link_valid;
    } result_t;

    logic                  r_s1_valid;
    logic [OP_WIDTH-1:0]   r_s1_op;
    logic [PC_WIDTH-1:0]   r_s1_pc;
    logic [WORD_WIDTH-1:0] r_s1_imm;
    logic [WORD_WIDTH-1:0] r_s1_rs1;
    logic [WORD_WIDTH-1:0] r_s1_rs2;
    logic [c_ROB_W-1:0]    r_s1_rob;
    logic                  r_s1_pred_taken;
    logic [PC_WIDTH-1:0]   r_s1_pred_addr;
    logic [CNT_WIDTH-1:0]  r_mispredict_cnt;

    logic [c_CNT_W-1:0]    w_fifo_count;
    logic                  w_issue_ready;
    logic                  w_fire;
    logic                  w_taken;
    logic                  w_link_op;
    logic [WORD_WIDTH-1:0] w_jalr_sum;
    logic [PC_WIDTH-1:0]   w_target;
    logic [PC_WIDTH-1:0]   w_pc4;
    result_t               w_result;
    result_t               w_head;
    logic                  w_head_valid;
    logic                  w_pop;

    // Credits cover both the FIFO and the op in stage 1, so stage 1 never stalls
    assign w_issue_ready = ~bus.flush &
                           ((w_fifo_count + c_CNT_W'(r_s1_valid)) < c_CNT_W'(OUT_DEPTH));
    assign w_fire        = bus.issue_valid & w_issue_ready;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_fire;
        end
        if (w_fire) begin
            r_s1_op         <= bus.issue_op;
            r_s1_pc         <= bus.issue_pc;
            r_s1_imm        <= bus.issue_imm;
            r_s1_rs1        <= bus.issue_rs1;
            r_s1_rs2        <= bus.issue_rs2;
            r_s1_rob        <= bus.issue_rob;
            r_s1_pred_taken <= bus.issue_pred_taken;
            r_s1_pred_addr  <= bus.issue_pred_addr;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_s1_op)
            OP_WIDTH'(BR_OP_BEQ):  w_taken = (r_s1_rs1 == r_s1_rs2);
            OP_WIDTH'(BR_OP_BNE):  w_taken = (r_s1_rs1 != r_s1_rs2);
            OP_WIDTH'(BR_OP_BLT):  w_taken = ($signed(r_s1_rs1) <  $signed(r_s1_rs2));
            OP_WIDTH'(BR_OP_BGE):  w_taken = ($signed(r_s1_rs1) >= $signed(r_s1_rs2));
            OP_WIDTH'(BR_OP_BLTU): w_taken = (r_s1_rs1 <  r_s1_rs2);
            OP_WIDTH'(BR_OP_BGEU): w_taken = (r_s1_rs1 >= r_s1_rs2);
            OP_WIDTH'(BR_OP_JAL),
            OP_WIDTH'(BR_OP_JALR): w_taken = 1'b1;
            default:               w_taken = 1'b0;
        endcase
    end

    assign w_link_op  = br_is_link(int'(r_s1_op));
    assign w_jalr_sum = r_s1_rs1 + r_s1_imm;
    assign w_pc4      = r_s1_pc + PC_WIDTH'(4);
    assign w_target   = (r_s1_op == OP_WIDTH'(BR_OP_JALR))
                      ? (PC_WIDTH'(w_jalr_sum) & ~PC_WIDTH'(1))
                      : (r_s1_pc + PC_WIDTH'($signed(r_s1_imm)));

    always_comb begin
        w_result            = '0;
        w_result.rob        = r_s1_rob;
        w_result.taken      = w_taken;
        w_result.next_pc    = w_taken ? w_target : w_pc4;
        w_result.mispredict = (w_taken != r_s1_pred_taken) |
                              (w_taken & (w_target != r_s1_pred_addr));
        w_result.misalign   = w_taken & (w_target[1:0] != 2'b00);
        w_result.link       = w_link_op ? WORD_WIDTH'(w_pc4) : '0;
        w_result.link_valid = w_link_op;
    end

    br_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.flush),
        .push       (r_s1_valid),
        .push_data  (w_result),
        .pop        (bus.out_ready),
        .head_valid (w_head_valid),
        .head_data  (w_head),
        .count      (w_fifo_count)
    );

    assign w_pop = w_head_valid & bus.out_ready;

    // Pops during a flush cycle still count: the consumer took the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredict_cnt <= '0;
        end else if (w_pop && w_head.mispredict && (r_mispredict_cnt != '1)) begin
            r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.issue_ready    = w_issue_ready;
    assign bus.out_valid      = w_head_valid;
    assign bus.out_rob        = w_head.rob;
    assign bus.out_taken      = w_head.taken;
    assign bus.out_next_pc    = w_head.next_pc;
    assign bus.out_mispredict = w_head.mispredict;
    assign bus.out_misalign   = w_head.misalign;
    assign bus.out_link       = w_head.link;
    assign bus.out_link_valid = w_head.link_valid;
    assign bus.mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire
